// File: rtl/packet_injector.sv
`default_nettype none
// ============================================================================
// Module  : packet_injector
// Brief   : Whole-packet to flit serializer with credit-based flow control
//           toward a single downstream router input buffer.
// Revision: 1.0
// ============================================================================
module packet_injector #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 5,
  parameter int BUFFER_DEPTH = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pkt_valid,
  output logic                                 pkt_ready,
  input  logic [PACKET_FLITS*FLIT_WIDTH-1:0]   pkt_data,
  output logic [FLIT_WIDTH:0]                  channel_out,
  input  logic                                 credit_in,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]    credit_count,
  output logic                                 busy,
  output logic                                 credit_overflow
);

  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int IW = $clog2(PACKET_FLITS);
  localparam int PW = PACKET_FLITS * FLIT_WIDTH;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(BUFFER_DEPTH);
  localparam logic [IW-1:0] LAST_IDX     = IW'(PACKET_FLITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   pkt_buf;
  logic [IW-1:0]   flit_idx;
  logic            send;

  // Decision is taken on the registered count, so a credit arriving at zero
  // only enables a flit on the following edge.
  assign send      = (state == SEND) && (credit_count != '0);
  assign pkt_ready = (state == IDLE);
  assign busy      = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pkt_buf         <= '0;
      flit_idx        <= '0;
      channel_out     <= '0;
      credit_count    <= FULL_CREDITS;
      credit_overflow <= 1'b0;
    end else begin
      channel_out <= '0;

      case (state)
        IDLE: begin
          if (pkt_valid) begin
            pkt_buf  <= pkt_data;
            flit_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (send) begin
            // Head sits in the MSB slice; shifting keeps the next flit on top.
            channel_out <= {1'b1, pkt_buf[PW-1 -: FLIT_WIDTH]};
            pkt_buf     <= pkt_buf << FLIT_WIDTH;
            flit_idx    <= flit_idx + IW'(1);
            if (flit_idx == LAST_IDX) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (send && !credit_in) begin
        credit_count <= credit_count - CW'(1);
      end else if (!send && credit_in) begin
        if (credit_count == FULL_CREDITS) begin
          credit_overflow <= 1'b1;
        end else begin
          credit_count <= credit_count + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_injector.sv
`default_nettype none
// ============================================================================
// Module  : tb_packet_injector
// Brief   : Directed bench for packet_injector with a queue-based reference.
// Revision: 1.0
// ============================================================================
module tb_packet_injector;

  localparam int FW = 32;
  localparam int PF = 5;
  localparam int BD = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [PF*FW-1:0]     pkt_data;
  logic [FW:0]          channel_out;
  logic                 credit_in;
  logic [2:0]           credit_count;
  logic                 busy;
  logic                 credit_overflow;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  packet_injector #(.FLIT_WIDTH(FW), .PACKET_FLITS(PF), .BUFFER_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .channel_out(channel_out), .credit_in(credit_in),
    .credit_count(credit_count), .busy(busy), .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PF*FW-1:0] mk(input logic [7:0] tag);
    logic [PF*FW-1:0] r;
    for (int i = 0; i < PF; i++) r[(PF-1-i)*FW +: FW] = {tag, 24'(i)};
    return r;
  endfunction

  function automatic logic [FW:0] fl(input logic [7:0] tag, input int i);
    return {1'b1, tag, 24'(i)};
  endfunction

  // Reference: a pending-flit queue; a flit leaves whenever a credit is held.
  logic [FW-1:0] mq[$];
  int            m_cnt = BD;
  bit            m_ovf = 1'b0;
  logic [FW:0]   m_ch  = '0;

  always @(posedge clk) begin
    bit snd;
    bit was_empty;
    int nc;
    if (reset) begin
      mq.delete();
      m_cnt = BD;
      m_ovf = 1'b0;
      m_ch  = '0;
    end else begin
      was_empty = (mq.size() == 0);
      snd       = !was_empty && (m_cnt > 0);
      m_ch      = '0;
      if (snd) m_ch = {1'b1, mq.pop_front()};
      if (was_empty && pkt_valid)
        for (int i = 0; i < PF; i++) mq.push_back(pkt_data[(PF-1-i)*FW +: FW]);
      nc = m_cnt - int'(snd) + int'(credit_in);
      if (nc > BD) begin
        nc    = BD;
        m_ovf = 1'b1;
      end
      m_cnt = nc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", channel_out[FW], m_ch[FW]);
      if (m_ch[FW]) chk("m_flit", channel_out[FW-1:0], m_ch[FW-1:0]);
      chk("m_credits", credit_count, m_cnt);
      chk("m_ready", pkt_ready, mq.size() == 0);
      chk("m_busy", busy, mq.size() != 0);
      chk("m_ovf", credit_overflow, m_ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [FW-1:0] vflit[$];
  int            vcyc[$];

  initial begin
    int cyc;
    int p;
    bit done;
    reset = 1'b1; pkt_valid = 1'b0; credit_in = 1'b0; pkt_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_credits", credit_count, 5);
    chk("rst_ready", pkt_ready, 1);
    chk("rst_chan", channel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", credit_overflow, 0);

    // Packet A with full credits
    pkt_valid = 1'b1; pkt_data = mk(8'hA0);
    @(negedge clk);
    pkt_valid = 1'b0;
    chk("a_accept_busy", busy, 1);
    chk("a_accept_valid", channel_out[FW], 0);
    for (int i = 0; i < PF; i++) begin
      @(negedge clk);
      chk("a_flit", channel_out, fl(8'hA0, i));
      chk("a_credits", credit_count, 64'(4 - i));
    end
    chk("a_ready_after", pkt_ready, 1);
    @(negedge clk);
    chk("a_idle_valid", channel_out[FW], 0);
    chk("a_credits_zero", credit_count, 0);

    // Packet B starved of credits
    pkt_valid = 1'b1; pkt_data = mk(8'hB0);
    @(negedge clk);
    pkt_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("b_stall_valid", channel_out[FW], 0);
      chk("b_stall_busy", busy, 1);
    end
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    chk("b_credit_arrive_valid", channel_out[FW], 0);
    chk("b_credit_arrive_cnt", credit_count, 1);
    @(negedge clk);
    chk("b_one_flit", channel_out, fl(8'hB0, 0));
    chk("b_cnt_back_zero", credit_count, 0);
    @(negedge clk);
    chk("b_stall_again", channel_out[FW], 0);
    credit_in = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (pkt_ready) done = 1'b1;
    end
    credit_in = 1'b0;
    chk("b_drain_done", done, 1);
    chk("b_last_flit", channel_out, fl(8'hB0, 4));
    chk("b_cnt_after", credit_count, 1);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    chk("c_pre_cnt", credit_count, 2);

    // Packet C with a credit returned every send cycle
    pkt_valid = 1'b1; pkt_data = mk(8'hC0);
    @(negedge clk);
    pkt_valid = 1'b0;
    credit_in = 1'b1;
    for (int i = 0; i < PF; i++) begin
      @(negedge clk);
      chk("c_flit", channel_out, fl(8'hC0, i));
      chk("c_cnt_steady", credit_count, 2);
    end
    // Refill to full, then one extra credit overflows
    repeat (3) @(negedge clk);
    chk("ovf_full_cnt", credit_count, 5);
    chk("ovf_not_yet", credit_overflow, 0);
    @(negedge clk);
    credit_in = 1'b0;
    chk("ovf_cnt_sat", credit_count, 5);
    chk("ovf_set", credit_overflow, 1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", credit_overflow, 1);

    // Packet D aborted by reset after its third flit
    pkt_valid = 1'b1; pkt_data = mk(8'hD0);
    @(negedge clk);
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d_flit", channel_out, fl(8'hD0, i));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("d_abort_valid", channel_out[FW], 0);
    chk("d_abort_cnt", credit_count, 5);
    chk("d_abort_ready", pkt_ready, 1);
    chk("d_abort_ovf", credit_overflow, 0);
    pkt_valid = 1'b1; pkt_data = mk(8'hE0);
    @(negedge clk);
    pkt_valid = 1'b0;
    for (int i = 0; i < PF; i++) begin
      @(negedge clk);
      chk("e_flit", channel_out, fl(8'hE0, i));
    end
    credit_in = 1'b1;
    repeat (5) @(negedge clk);
    credit_in = 1'b0;
    chk("f_pre_cnt", credit_count, 5);

    // Three packets with pkt_valid held high and immediate credit return
    cyc = 0; p = 0;
    for (int c = 0; c < 80 && vflit.size() < 3 * PF; c++) begin
      if (pkt_ready && p < 3) begin
        pkt_data  = mk(8'(8'hF0 + p));
        pkt_valid = 1'b1;
        p++;
      end else if (p >= 3) begin
        pkt_valid = 1'b0;
      end
      credit_in = channel_out[FW];
      @(negedge clk);
      cyc++;
      if (channel_out[FW]) begin
        vflit.push_back(channel_out[FW-1:0]);
        vcyc.push_back(cyc);
      end
    end
    pkt_valid = 1'b0;
    credit_in = 1'b0;
    chk("f_flit_total", vflit.size(), 3 * PF);
    for (int k = 0; k < vflit.size() && k < 3 * PF; k++) begin
      chk("f_order", vflit[k], {8'(8'hF0 + k / PF), 24'(k % PF)});
      if (k > 0) chk("f_spacing", vcyc[k] - vcyc[k-1], (k % PF == 0) ? 2 : 1);
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
